// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_arb_pkg : shared types and constants for the SRAM port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic CLIENT_FETCH = 1'b0;
    localparam logic CLIENT_WB    = 1'b1;
    localparam logic DIR_READ     = 1'b0;
    localparam logic DIR_WRITE    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_port_arbiter : round-robin sharing of one SRAM port between two clients
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 24,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] w_data_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              read_enable_o,
    output logic              write_enable_o
);

    localparam int               CNT_W    = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              dir_q, dir_d;
    logic              last_owner_q, last_owner_d;
    logic              last_dir_q, last_dir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              pick;

    // On a tie the client that did not own the port last time wins.
    always_comb begin
        pick = CLIENT_FETCH;
        if (req_i == 2'b10) begin
            pick = CLIENT_WB;
        end else if (req_i == 2'b11) begin
            pick = ~last_owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= CLIENT_FETCH;
            dir_q        <= DIR_READ;
            last_owner_q <= CLIENT_WB;
            last_dir_q   <= DIR_READ;
            cnt_q        <= '0;
            address_q    <= '0;
            wdata_hold_q <= '0;
            w_data_q     <= '0;
            rdata_q      <= '0;
            gnt_q        <= 2'b00;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            dir_q        <= dir_d;
            last_owner_q <= last_owner_d;
            last_dir_q   <= last_dir_d;
            cnt_q        <= cnt_d;
            address_q    <= address_d;
            wdata_hold_q <= wdata_hold_d;
            w_data_q     <= w_data_d;
            rdata_q      <= rdata_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            re_q         <= re_d;
            we_q         <= we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        dir_d        = dir_q;
        last_owner_d = last_owner_q;
        last_dir_d   = last_dir_q;
        cnt_d        = cnt_q;
        address_d    = address_q;
        wdata_hold_d = wdata_hold_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    owner_d      = pick;
                    dir_d        = we_i[pick];
                    address_d    = (pick == CLIENT_WB) ? addr1_i : addr0_i;
                    wdata_hold_d = (pick == CLIENT_WB) ? wdata1_i : wdata0_i;
                    cnt_d        = CNT_LOAD;
                    state_d      = (we_i[pick] != last_dir_q) ? TURN : ACCESS;
                end
            end
            TURN: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    if (dir_q == DIR_READ) begin
                        rdata_d = r_data_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                last_dir_d   = dir_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that every port comes straight from a flop.
    always_comb begin
        gnt_d    = 2'b00;
        ack_d    = 2'b00;
        busy_d   = (state_d != IDLE);
        re_d     = 1'b0;
        we_d     = 1'b0;
        w_data_d = '0;
        if (state_d != IDLE) begin
            gnt_d = (owner_d == CLIENT_WB) ? 2'b10 : 2'b01;
        end
        if (state_d == DONE) begin
            ack_d = gnt_d;
        end
        if (state_d == ACCESS) begin
            re_d = (dir_d == DIR_READ);
            we_d = (dir_d == DIR_WRITE);
            if (dir_d == DIR_WRITE) begin
                w_data_d = wdata_hold_d;
            end
        end
    end

    assign gnt_o          = gnt_q;
    assign ack_o          = ack_q;
    assign rdata_o        = rdata_q;
    assign busy_o         = busy_q;
    assign address_o      = address_q;
    assign w_data_o       = w_data_q;
    assign read_enable_o  = re_q;
    assign write_enable_o = we_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_port_arbiter : directed bench with a transaction-timeline model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int AC1 = 1;
    localparam int AC3 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b1;
    logic [1:0]  req = 2'b00, we = 2'b00, req3 = 2'b00, we3 = 2'b00;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [23:0] wdata0 = '0, wdata1 = '0;

    logic [1:0]  gnt, ack, gnt3, ack3;
    logic [23:0] rdata, w_data, r_data, rdata3, w_data3, r_data3;
    logic [15:0] address, address3;
    logic        busy, read_enable, write_enable, busy3, re3, wr3;

    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [23:0] bd_data = '0;
    logic [23:0] mem  [0:65535];
    logic [23:0] mem3 [0:65535];
    int          wcnt1 = 0, wcnt3 = 0;

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(16), .DATA_W(24), .ACCESS_CYCLES(AC1)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt), .ack_o(ack), .rdata_o(rdata), .busy_o(busy),
        .address_o(address), .w_data_o(w_data), .r_data_i(r_data),
        .read_enable_o(read_enable), .write_enable_o(write_enable)
    );

    sram_port_arbiter #(.ADDR_W(16), .DATA_W(24), .ACCESS_CYCLES(AC3)) dut3 (
        .clk(clk), .rst(rst3), .req_i(req3), .we_i(we3),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt3), .ack_o(ack3), .rdata_o(rdata3), .busy_o(busy3),
        .address_o(address3), .w_data_o(w_data3), .r_data_i(r_data3),
        .read_enable_o(re3), .write_enable_o(wr3)
    );

    // SRAMs: combinational read, a write commits only after a full-length strobe.
    assign r_data  = mem[address];
    assign r_data3 = mem3[address3];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (write_enable) begin
            if (wcnt1 + 1 == AC1) begin
                mem[address] <= w_data;
                wcnt1 <= 0;
            end else begin
                wcnt1 <= wcnt1 + 1;
            end
        end else begin
            wcnt1 <= 0;
        end
    end

    always @(posedge clk) begin
        if (bd_we) mem3[bd_addr] <= bd_data;
        if (wr3) begin
            if (wcnt3 + 1 == AC3) begin
                mem3[address3] <= w_data3;
                wcnt3 <= 0;
            end else begin
                wcnt3 <= wcnt3 + 1;
            end
        end else begin
            wcnt3 <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: one transaction = optional turnaround, AC1 strobe cycles, one ack cycle.
    bit          m_active = 1'b0, m_turn = 1'b0, m_owner = 1'b0, m_dir = 1'b0;
    bit          m_last_owner = 1'b1, m_last_dir = 1'b0;
    int          m_t = 0;
    logic [15:0] m_addr = '0;
    logic [23:0] m_wdata = '0, m_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_last_owner = 1'b1; m_last_dir = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_t = 0;
        end else if (m_active) begin
            if (m_t == int'(m_turn) + AC1) begin
                m_active = 1'b0;
                m_last_owner = m_owner;
                m_last_dir = m_dir;
            end else begin
                if (m_t == int'(m_turn) + AC1 - 1 && !m_dir) m_rdata = mem[m_addr];
                m_t++;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_owner = !m_last_owner;
            else m_owner = req[1];
            m_dir   = we[m_owner];
            m_addr  = m_owner ? addr1 : addr0;
            m_wdata = m_owner ? wdata1 : wdata0;
            m_turn  = (m_dir != m_last_dir);
            m_t     = 0;
            m_active = 1'b1;
        end
    end

    bit         e_acc, e_done;
    logic [1:0] e_own;

    always @(negedge clk) begin
        if (chk_en) begin
            e_acc  = m_active && m_t >= int'(m_turn) && m_t < int'(m_turn) + AC1;
            e_done = m_active && m_t == int'(m_turn) + AC1;
            e_own  = m_owner ? 2'b10 : 2'b01;
            check("gnt", gnt, m_active ? e_own : 2'b00);
            check("ack", ack, e_done ? e_own : 2'b00);
            check("busy", busy, m_active);
            check("read_enable", read_enable, e_acc && !m_dir);
            check("write_enable", write_enable, e_acc && m_dir);
            check("w_data", w_data, (e_acc && m_dir) ? m_wdata : 24'h0);
            check("address", address, m_addr);
            check("rdata", rdata, m_rdata);
            check("enable_excl", read_enable & write_enable, 1'b0);
        end
    end

    task automatic poke(input logic [15:0] a, input logic [23:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic wait_ack(input int c, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack[c] && cyc < 12);
        check("ack_seen", ack[c], 1'b1);
    endtask

    task automatic wait_any(output int who, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack == 2'b00 && cyc < 12);
        check("any_ack_seen", ack != 2'b00, 1'b1);
        who = ack[1] ? 1 : 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, who, cnt0, cnt1;
        bit ackseen;
        for (int i = 0; i < 20; i++) begin
            poke(16'(i), 24'hC00000 + 24'(i * 257));
            chk_en = 1'b1;
        end
        poke(16'h0014, 24'h80FF10);
        poke(16'h0200, 24'h000000);
        rst = 1'b0; rst3 = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_address", address, 16'h0000);
        check("rst_rdata", rdata, 24'h0);

        // single read
        addr0 = 16'h0014; we = 2'b00; req = 2'b01;
        wait_ack(0, cyc);
        check("t1_latency", cyc, 2);
        check("t1_rdata", rdata, 24'h80FF10);
        req = 2'b00; @(negedge clk);

        // tie after reset
        reset_dut();
        addr1 = 16'h0003; req = 2'b11;
        @(negedge clk);
        check("t2_gnt_first", gnt, 2'b01);
        wait_ack(0, cyc);
        check("t2_lat0", cyc, 1);
        req = 2'b10;
        wait_ack(1, cyc);
        check("t2_lat1", cyc, 3);
        check("t2_gnt_second", gnt, 2'b10);
        check("t2_rdata1", rdata, 24'hC00303);
        req = 2'b00; @(negedge clk);

        // direction change write then read
        addr1 = 16'h0100; wdata1 = 24'hABCDEF; we = 2'b10; req = 2'b10;
        @(negedge clk);
        check("t3_turn_re", read_enable, 1'b0);
        check("t3_turn_we", write_enable, 1'b0);
        check("t3_turn_busy", busy, 1'b1);
        wait_ack(1, cyc);
        check("t3_wr_rest", cyc, 2);
        check("t3_mem", mem[16'h0100], 24'hABCDEF);
        req = 2'b00; we = 2'b00; @(negedge clk);
        addr0 = 16'h0100; req = 2'b01;
        wait_ack(0, cyc);
        check("t3_rd_lat", cyc, 3);
        check("t3_rdata", rdata, 24'hABCDEF);
        req = 2'b00; @(negedge clk);

        // fairness with both requests held
        addr0 = 16'h0005; addr1 = 16'h0006; req = 2'b11;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 20; i++) begin
            wait_any(who, cyc);
            check("t4_order", who, (i % 2 == 0) ? 1 : 0);
            check("t4_period", cyc, (i == 0) ? 2 : 3);
            if (who == 1) cnt1++;
            else cnt0++;
        end
        req = 2'b00;
        check("t4_cnt0", cnt0, 10);
        check("t4_cnt1", cnt1, 10);
        @(negedge clk);

        // back-to-back reads from client 0
        addr0 = 16'h0000; req = 2'b01;
        for (int i = 0; i < 20; i++) begin
            wait_ack(0, cyc);
            check("t6_period", cyc, (i == 0) ? 2 : 3);
            check("t6_rdata", rdata, 24'hC00000 + 24'(i * 257));
            addr0 = 16'(i + 1);
        end
        req = 2'b00; @(negedge clk);

        // reset in the middle of a 3-cycle write
        addr0 = 16'h0200; wdata0 = 24'h123456; we3 = 2'b01; req3 = 2'b01;
        @(negedge clk);
        check("t5_turn_busy", busy3, 1'b1);
        check("t5_turn_we", wr3, 1'b0);
        @(negedge clk);
        check("t5_acc_we", wr3, 1'b1);
        check("t5_acc_gnt", gnt3, 2'b01);
        rst3 = 1'b1; req3 = 2'b00;
        @(negedge clk);
        check("t5_rst_re", re3, 1'b0);
        check("t5_rst_we", wr3, 1'b0);
        check("t5_rst_gnt", gnt3, 2'b00);
        check("t5_rst_ack", ack3, 2'b00);
        check("t5_rst_busy", busy3, 1'b0);
        rst3 = 1'b0;
        ackseen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack3 != 2'b00) ackseen = 1'b1;
        end
        check("t5_no_ack", ackseen, 1'b0);
        check("t5_no_write", mem3[16'h0200], 24'h000000);
        req3 = 2'b01; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack3[0] && cyc < 12);
        check("t5_full_lat", cyc, 5);
        check("t5_mem", mem3[16'h0200], 24'h123456);
        req3 = 2'b00; we3 = 2'b00;
        @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
